// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the multi-cycle DIV/DIVU unit and the decode/execute
// stages that drive it: FSM state encodings, ready/start levels and the
// operator codes that select the divider.
// -----------------------------------------------------------------------------
package divider_pkg;

  // Operand width the unit is built and verified for.
  localparam int DIV_WIDTH = 32;

  // Divider FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    DIV_STATE_IDLE    = 2'd0,
    DIV_STATE_BY_ZERO = 2'd1,
    DIV_STATE_RUNNING = 2'd2,
    DIV_STATE_DONE    = 2'd3
  } div_state_e;

  // Levels of the ready output.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Levels of the start input.
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // Operator codes (SPECIAL funct field) used by decode and execute.
  localparam logic [5:0] OPERATOR_DIV  = 6'h1A;
  localparam logic [5:0] OPERATOR_DIVU = 6'h1B;

  // True when the operator is routed to the divider.
  function automatic logic is_div_operator(input logic [5:0] op);
    return (op == OPERATOR_DIV) || (op == OPERATOR_DIVU);
  endfunction

  // Value to drive on signed_div for a divider operator.
  function automatic logic is_signed_div_operator(input logic [5:0] op);
    return (op == OPERATOR_DIV);
  endfunction

endpackage

// File: rtl/divider_clz.sv
// -----------------------------------------------------------------------------
// divider_clz
// Combinational leading-zero counter. Used by the divider's early-termination
// mode and reusable by the CLZ/CLO execute path (feed ~x to count ones).
//
// Ports:
//   value_i  input  [WIDTH-1:0]  value to scan
//   count_o  output [CW-1:0]     number of leading zeros, WIDTH when value_i==0
// -----------------------------------------------------------------------------
module divider_clz #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [CW-1:0]    count_o
);

  // Scan from the LSB upward so the highest set bit is the last to write.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value_i[i]) begin
        count_o = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Multi-cycle radix-2 restoring divider for DIV (signed) and DIVU (unsigned).
// One division in flight at a time.
//
// Handshake: the execute stage raises start with the operands and keeps it
// high; the request is accepted on the first edge in IDLE with start=1 and
// annul=0, and operands/signed_div are sampled only on that edge. ready rises
// when result is valid and both stay stable while start remains high; the
// first edge with start=0 returns the unit to IDLE with ready=0, result=0.
// annul forces IDLE on the next edge from any state.
//
// Ports:
//   clock       input   rising-edge clock
//   reset       input   synchronous, active-high reset
//   start       input   request, held until the result is consumed
//   annul       input   abort current operation (pipeline flush)
//   signed_div  input   1 = DIV, 0 = DIVU
//   operand_a   input   [WIDTH-1:0] dividend
//   operand_b   input   [WIDTH-1:0] divisor
//   result      output  [2*WIDTH-1:0] {remainder, quotient}, registered
//   ready       output  result valid, registered
//
// Build option: define DIVIDER_EARLY_TERM_EN to skip the leading zeros of
// |dividend| (latency WIDTH-n steps); results are identical either way.
// -----------------------------------------------------------------------------
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               annul,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int             CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  div_state_e           state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0]     dvd_q, dvd_d;       // dividend bits still to consume, MSB first
  logic [WIDTH-1:0]     dvs_q, dvs_d;       // divisor magnitude
  logic [WIDTH-1:0]     quo_q, quo_d;       // quotient bits produced so far
  logic [CW-1:0]        cnt_q, cnt_d;       // step counter
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  // ---------------------------------------------------------------------------
  // Operand magnitudes (two's complement negation only for DIV).
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] abs_a, abs_b;

  assign abs_a = (signed_div && operand_a[WIDTH-1]) ? (~operand_a + ONE) : operand_a;
  assign abs_b = (signed_div && operand_b[WIDTH-1]) ? (~operand_b + ONE) : operand_b;

  // ---------------------------------------------------------------------------
  // Start-of-run values for the dividend shifter and counter.
  // With early termination, the dividend is pre-shifted past its leading zeros
  // and the counter starts at n, so the run still ends at LAST_STEP.
  // ---------------------------------------------------------------------------
  logic             zero_dvd;
  logic [WIDTH-1:0] dvd_init;
  logic [CW-1:0]    cnt_init;

`ifdef DIVIDER_EARLY_TERM_EN
  logic [CW-1:0] lead_zeros;

  divider_clz #(
    .WIDTH (WIDTH)
  ) u_clz (
    .value_i (abs_a),
    .count_o (lead_zeros)
  );

  // A zero dividend has nothing to shift in; its result is all zeros, the
  // same as the divide-by-zero result, so it reuses that one-cycle path.
  assign zero_dvd = (abs_a == '0);
  assign dvd_init = abs_a << lead_zeros;
  assign cnt_init = lead_zeros;
`else
  assign zero_dvd = 1'b0;
  assign dvd_init = abs_a;
  assign cnt_init = '0;
`endif

  // ---------------------------------------------------------------------------
  // One restoring step. {rem, next bit} < 2*divisor always holds, so the
  // WIDTH+1-bit difference never wraps and its MSB is the borrow.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  assign trial    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign q_bit    = ~trial[WIDTH];
  assign rem_step = q_bit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign quo_step = {quo_q[WIDTH-2:0], q_bit};

  // Sign fix applied on the final step; wraps modulo 2^WIDTH, so
  // most-negative / -1 yields the most-negative quotient without a trap.
  assign quo_fix = neg_quo_q ? (~quo_step + ONE) : quo_step;
  assign rem_fix = neg_rem_q ? (~rem_step + ONE) : rem_step;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    if (annul) begin
      state_d  = DIV_STATE_IDLE;
      ready_d  = DIV_RESULT_NOT_READY;
      result_d = '0;
    end else begin
      case (state_q)
        DIV_STATE_IDLE: begin
          if (start == DIV_START) begin
            dvs_d     = abs_b;
            rem_d     = '0;
            quo_d     = '0;
            neg_quo_d = signed_div & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_rem_d = signed_div & operand_a[WIDTH-1];
            if ((operand_b == '0) || zero_dvd) begin
              state_d = DIV_STATE_BY_ZERO;
            end else begin
              dvd_d   = dvd_init;
              cnt_d   = cnt_init;
              state_d = DIV_STATE_RUNNING;
            end
          end
        end

        DIV_STATE_BY_ZERO: begin
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_STATE_DONE;
        end

        DIV_STATE_RUNNING: begin
          rem_d = rem_step;
          quo_d = quo_step;
          dvd_d = dvd_q << 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            result_d = {rem_fix, quo_fix};
            ready_d  = DIV_RESULT_READY;
            state_d  = DIV_STATE_DONE;
          end
        end

        DIV_STATE_DONE: begin
          if (start == DIV_STOP) begin
            state_d  = DIV_STATE_IDLE;
            ready_d  = DIV_RESULT_NOT_READY;
            result_d = '0;
          end
        end

        default: begin
          state_d  = DIV_STATE_IDLE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= DIV_STATE_IDLE;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
// Self-checking bench for divider: directed DIV/DIVU cases, divide-by-zero,
// annul/reset abort with restart, early-termination cases and randomized
// operations, all checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_divider;

  localparam int W = 32;

  logic           clock;
  logic           reset;
  logic           start;
  logic           annul;
  logic           signed_div;
  logic [W-1:0]   operand_a;
  logic [W-1:0]   operand_b;
  logic [2*W-1:0] result;
  logic           ready;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] exp_q[$];

  divider #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .ready      (ready)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model: plain 64-bit signed arithmetic. SV division truncates
  // toward zero and % takes the sign of the dividend, matching DIV.
  // ---------------------------------------------------------------------------
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
    longint sa, sb, q, r;
    logic [W-1:0] q32, r32;
    if (b == '0) return '0;
    sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q   = sa / sb;
    r   = sa % sb;
    q32 = q[W-1:0];
    r32 = r[W-1:0];
    return {r32, q32};
  endfunction

  // Edges from accept to ready.
  function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic sgn);
    longint sa, mag;
    int bits;
    if (b == '0) return 1;
    sa   = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    mag  = (sa < 0) ? -sa : sa;
    bits = 0;
    while (mag > 0) begin
      bits++;
      mag = mag / 2;
    end
`ifdef DIVIDER_EARLY_TERM_EN
    return (bits == 0) ? 1 : bits;
`else
    return W;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Comparison point
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [2*W-1:0] observed,
                       input logic [2*W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one full operation with accept, latency, hold and release checks.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn);
    int cycles;
    int exp_lat;
    logic [2*W-1:0] exp_res;
    exp_q.push_back(ref_div(a, b, sgn));
    exp_lat = ref_latency(a, b, sgn);

    @(negedge clock);
    operand_a  = a;
    operand_b  = b;
    signed_div = sgn;
    start      = 1'b1;
    @(posedge clock);  // accept edge k
    #1;
    // Operand changes after accept must not matter.
    operand_a  = $urandom;
    operand_b  = $urandom;
    signed_div = 1'($urandom_range(0, 1));

    cycles = 0;
    while (ready !== 1'b1 && cycles < 40) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    exp_res = exp_q.pop_front();
    check({tag, " ready"},   {63'd0, ready}, 64'd1);
    check({tag, " latency"}, 64'(cycles), 64'(exp_lat));
    check({tag, " result"},  result, exp_res);

    // Held while start stays high.
    @(posedge clock);
    #1;
    check({tag, " hold ready"},  {63'd0, ready}, 64'd1);
    check({tag, " hold result"}, result, exp_res);

    // Drop start: back to idle on the next edge.
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    check({tag, " release ready"},  {63'd0, ready}, 64'd0);
    check({tag, " release result"}, result, 64'd0);
  endtask

  // Abort a run at step 10 with annul or reset, then restart with DIVU 9/3.
  task automatic abort_op(input string tag, input logic use_reset);
    @(negedge clock);
    operand_a  = 32'hFFFF_FFF0;  // no leading zeros: full-length run in every build
    operand_b  = 32'd3;
    signed_div = 1'b0;
    start      = 1'b1;
    @(posedge clock);  // accept edge k
    repeat (9) @(posedge clock);
    @(negedge clock);
    if (use_reset) reset = 1'b1;
    else           annul = 1'b1;
    @(posedge clock);  // edge k+10
    #1;
    check({tag, " ready"},  {63'd0, ready}, 64'd0);
    check({tag, " result"}, result, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    annul = 1'b0;
    start = 1'b0;
    @(posedge clock);
    run_op({tag, " restart 9/3"}, 32'd9, 32'd3, 1'b0);
  endtask

  function automatic logic [W-1:0] pick_operand(input int sel);
    case (sel)
      0:       return W'($urandom_range(0, 20));
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom) >> $urandom_range(0, 31);
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    reset      = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    operand_a  = '0;
    operand_b  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset ready",  {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("divu 100/7",        32'd100,       32'd7,         1'b0);
    check("divu 100/7 literal", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    run_op("div -7/2",          32'hFFFF_FFF9, 32'd2,         1'b1);
    run_op("div 7/-2",          32'd7,         32'hFFFF_FFFE, 1'b1);
    run_op("div min/-1",        32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("divu min/max",      32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu 5/0",          32'd5,         32'd0,         1'b0);
    run_op("div -5/0",          32'hFFFF_FFFB, 32'd0,         1'b1);

    abort_op("annul", 1'b0);
    abort_op("reset", 1'b1);

    run_op("divu 15/3", 32'd15, 32'd3, 1'b0);
    run_op("divu 0/9",  32'd0,  32'd9, 1'b0);
    run_op("div 1/max", 32'd1,  32'hFFFF_FFFF, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = pick_operand($urandom_range(0, 7));
      rb = ($urandom_range(0, 9) == 0) ? 32'd0 : pick_operand($urandom_range(0, 7));
      if (rb == '0 && $urandom_range(0, 1) == 1) rb = 32'd1;
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d %h/%h s%0d", i, ra, rb, rs), ra, rb, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
